score_stream_tx: RTL and testbench
==================================

// Module: score_stream_tx
// PURPOSE
//  Transmit end of the class-score bus feeding the argmax stage. Captures the
//  NUM_CLASSES scores from the output (dense) layer in one parallel load, then
//  streams them one word per valid/ready handshake, in index order 0..N-1.
//  Each word carries its class index and a last flag. Sits between the final
//  layer and the argmax/Max activation receiver.
// PARAMETERS
//  NUM_CLASSES  10  scores per frame (2..15)
//  DATA_W       16  score width, two's complement
//  IDX_W        4   class-index width; index 4'hF is reserved
// PORTS
//  Tx_Clock     in   1                      single clock, rising edge
//  Tx_Reset_n   in   1                      asynchronous, active-low reset
//  Tx_Load      in   1                      load pulse; accepted only in IDLE
//  Tx_LoadBUS   in   NUM_CLASSES*DATA_W     score k at bits [k*DATA_W +: DATA_W]
//  Tx_Busy      out  1                      high from load accept to frame end
//  Tx_Overrun   out  1                      1-cycle pulse: Tx_Load while busy
//  Tx_Valid     out  1                      Tx_OutBUS/Tx_Index/Tx_Last valid
//  Tx_Ready     in   1                      receiver accepts the word
//  Tx_OutBUS    out  DATA_W                 current score
//  Tx_Index     out  IDX_W                  class index of current word
//  Tx_Last      out  1                      final word of the frame
//  Tx_Done      out  1                      1-cycle pulse after last handshake
// BEHAVIOUR
//  - Reset (async assert, sync release): state IDLE. Tx_Busy, Tx_Overrun,
//    Tx_Valid, Tx_Last and Tx_Done = 0. Tx_OutBUS = 0, Tx_Index = 0.
//    Buffer cleared. A reset mid-frame discards the frame; no Tx_Done.
//  - FSM: IDLE -> SEND when Tx_Load=1 in IDLE. The buffer is captured on that
//    edge. Tx_Busy=1 and Tx_Valid=1 from the next cycle, with Index 0.
//  - SEND: a handshake is Tx_Valid & Tx_Ready at a rising edge. On each
//    handshake the index advances and the next word appears the following
//    cycle, with Tx_Valid held high. This gives 1 word per cycle when Ready
//    is held high.
//  - Valid rules: Tx_Valid never depends combinationally on Tx_Ready. While
//    Tx_Valid=1 and Ready=0, OutBUS/Index/Last hold stable. Tx_Valid never
//    drops without a handshake.
//  - Tx_Last=1 only with the word at index NUM_CLASSES-1 (or the checksum word
//    when that feature is enabled).
//  - Handshake on the Last word -> back to IDLE. On the next cycle: Valid=0,
//    Busy=0, Last=0, Tx_Done=1 for exactly 1 cycle. A new Tx_Load in that same
//    Done cycle is accepted.
//  - Frame length is NUM_CLASSES cycles minimum, plus 1 cycle load latency.
//  - Tx_Load while in SEND or SUM: the load is ignored, the buffer is
//    untouched, and Tx_Overrun pulses the next cycle.
//  - The index counter is IDX_W bits. It is compared to NUM_CLASSES-1, so it
//    never wraps. Scores pass through unmodified; no arithmetic on data.
// CONFIGURATION
//  SCORE_TX_CHECKSUM_EN defined:
//  - After index NUM_CLASSES-1 the FSM enters state SUM and sends one extra
//    word.
//  - That word has Tx_OutBUS = the modulo-2^DATA_W sum of all scores,
//    Tx_Index = 4'hF and Tx_Last = 1.
//  - Word NUM_CLASSES-1 then has Last = 0. The sum is computed during capture.
//  SCORE_TX_CHECKSUM_EN undefined:
//  - No SUM state and no adder; the frame is exactly NUM_CLASSES words.
// TESTING
//  1. Reset, then load scores k*100 (k=0..9) with Ready=1 -> 10 words on
//     consecutive cycles, Index 0..9, OutBUS 0,100..900, Last only at
//     Index 9, Done 1 cycle later.
//  2. Ready toggled 1-0-0-1 pattern -> words held stable while Ready=0; no
//     skip or duplicate; order 0..9 preserved.
//  3. Tx_Load pulsed at the 3rd word with new data -> Overrun pulse;
//     remaining words still from the first load; Busy stays 1.
//  4. Tx_Reset_n=0 at Index 5 with Ready=0 -> Valid, Busy, Index and OutBUS
//     go to 0 immediately; no Done; a fresh load then restarts at Index 0.
//  5. Scores -32768, 32767, -1, 0..0 (signed extremes) -> passed bit-exact
//     (16'h8000, 16'h7FFF, 16'hFFFF).
//  6. With SCORE_TX_CHECKSUM_EN, scores all 16'h2000 -> 11th word is
//     OutBUS=16'h4000, Index=4'hF, Last=1; word 9 has Last=0.

Source files
------------

// File: rtl/score_stream_tx.sv
// -----------------------------------------------------------------------------
// score_stream_tx
//   Transmit end of the class-score bus feeding the argmax stage. A single
//   Tx_Load pulse in IDLE captures NUM_CLASSES scores in parallel. The scores
//   are then streamed one word per valid/ready handshake, in index order
//   0..NUM_CLASSES-1. Each word carries its class index and a last flag.
//
//   Optional feature (macro SCORE_TX_CHECKSUM_EN):
//     When defined, one extra word follows the scores. It carries the
//     modulo-2^DATA_W sum of all scores, with index all-ones and Last=1.
//     When undefined there is no SUM state and no adder.
//
// Ports
//   Tx_Clock    in   clock, rising edge
//   Tx_Reset_n  in   asynchronous active-low reset
//   Tx_Load     in   load pulse; accepted only in IDLE
//   Tx_LoadBUS  in   scores; score k at [k*DATA_W +: DATA_W]
//   Tx_Busy     out  high from load accept to frame end
//   Tx_Overrun  out  1-cycle pulse after a Tx_Load seen while busy
//   Tx_Valid    out  Tx_OutBUS/Tx_Index/Tx_Last are valid
//   Tx_Ready    in   receiver accepts the current word
//   Tx_OutBUS   out  current score (or checksum)
//   Tx_Index    out  class index of the current word
//   Tx_Last     out  final word of the frame
//   Tx_Done     out  1-cycle pulse after the last handshake
// -----------------------------------------------------------------------------
module score_stream_tx #(
  parameter int NUM_CLASSES = 10,
  parameter int DATA_W      = 16,
  parameter int IDX_W       = 4
) (
  input  logic                          Tx_Clock,
  input  logic                          Tx_Reset_n,
  input  logic                          Tx_Load,
  input  logic [NUM_CLASSES*DATA_W-1:0] Tx_LoadBUS,
  output logic                          Tx_Busy,
  output logic                          Tx_Overrun,
  output logic                          Tx_Valid,
  input  logic                          Tx_Ready,
  output logic [DATA_W-1:0]             Tx_OutBUS,
  output logic [IDX_W-1:0]              Tx_Index,
  output logic                          Tx_Last,
  output logic                          Tx_Done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

`ifdef SCORE_TX_CHECKSUM_EN
  localparam logic [IDX_W-1:0] SUM_IDX = '1;  // reserved index tags the checksum
  typedef enum logic [1:0] {S_IDLE, S_SEND, S_SUM} state_e;
`else
  typedef enum logic [1:0] {S_IDLE, S_SEND} state_e;
`endif

  state_e                        state_q, state_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic [NUM_CLASSES*DATA_W-1:0] buf_q, buf_d;
  logic                          done_q, done_d;
  logic                          overrun_q, overrun_d;
  logic                          handshake;

`ifdef SCORE_TX_CHECKSUM_EN
  logic [DATA_W-1:0]             sum_q, sum_d;
  logic [DATA_W-1:0]             load_sum;

  // Checksum is formed from the bus being captured, so it is ready by the
  // time the SUM word goes out.
  always_comb begin
    load_sum = '0;
    for (int k = 0; k < NUM_CLASSES; k++) begin
      load_sum = load_sum + Tx_LoadBUS[k*DATA_W +: DATA_W];
    end
  end
`endif

  // Valid comes straight from the state register, never from Tx_Ready.
  assign Tx_Valid   = (state_q != S_IDLE);
  assign Tx_Busy    = (state_q != S_IDLE);
  assign Tx_Done    = done_q;
  assign Tx_Overrun = overrun_q;
  assign handshake  = Tx_Valid & Tx_Ready;

  // Next-state logic
  always_comb begin
    // NOTE: every signal gets a default before the case so no path can leave
    // it unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    idx_d     = idx_q;
    buf_d     = buf_q;
    done_d    = 1'b0;
    overrun_d = 1'b0;
`ifdef SCORE_TX_CHECKSUM_EN
    sum_d     = sum_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (Tx_Load) begin
          buf_d   = Tx_LoadBUS;
          idx_d   = '0;
          state_d = S_SEND;
`ifdef SCORE_TX_CHECKSUM_EN
          sum_d   = load_sum;
`endif
        end
      end

      S_SEND: begin
        overrun_d = Tx_Load;  // load ignored, buffer untouched
        if (handshake) begin
          if (idx_q == LAST_IDX) begin
`ifdef SCORE_TX_CHECKSUM_EN
            state_d = S_SUM;
`else
            state_d = S_IDLE;
            done_d  = 1'b1;
            idx_d   = '0;
`endif
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end

`ifdef SCORE_TX_CHECKSUM_EN
      S_SUM: begin
        overrun_d = Tx_Load;
        if (handshake) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          idx_d   = '0;
        end
      end
`endif

      default: state_d = S_IDLE;
    endcase
  end

  // Output word mux; all zeros whenever no word is being offered.
  always_comb begin
    Tx_OutBUS = '0;
    Tx_Index  = '0;
    Tx_Last   = 1'b0;
    unique case (state_q)
      S_SEND: begin
        Tx_OutBUS = buf_q[int'(idx_q)*DATA_W +: DATA_W];
        Tx_Index  = idx_q;
`ifdef SCORE_TX_CHECKSUM_EN
        Tx_Last   = 1'b0;
`else
        Tx_Last   = (idx_q == LAST_IDX);
`endif
      end
`ifdef SCORE_TX_CHECKSUM_EN
      S_SUM: begin
        Tx_OutBUS = sum_q;
        Tx_Index  = SUM_IDX;
        Tx_Last   = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // State registers
  // NOTE: the score buffer is reset too, so a frame discarded by reset never
  // leaks stale scores onto Tx_OutBUS.
  always_ff @(posedge Tx_Clock or negedge Tx_Reset_n) begin
    if (!Tx_Reset_n) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      buf_q     <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
`ifdef SCORE_TX_CHECKSUM_EN
      sum_q     <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q   <= state_d;
      idx_q     <= idx_d;
      buf_q     <= buf_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
`ifdef SCORE_TX_CHECKSUM_EN
      sum_q     <= sum_d;
`endif
    end
  end

endmodule

// File: tb/tb_score_stream_tx.sv
// -----------------------------------------------------------------------------
// tb_score_stream_tx
//   Scoreboard bench for score_stream_tx. Expected words are pushed when a
//   frame is loaded and popped on every observed handshake. Outputs are
//   sampled on the falling edge; inputs change 1 time unit after the rising
//   edge.
// -----------------------------------------------------------------------------
module tb_score_stream_tx;

  localparam int N  = 10;
  localparam int DW = 16;
  localparam int IW = 4;

  typedef struct {
    logic [DW-1:0] data;
    logic [IW-1:0] idx;
    logic          last;
  } word_t;

  logic              Tx_Clock;
  logic              Tx_Reset_n;
  logic              Tx_Load;
  logic [N*DW-1:0]   Tx_LoadBUS;
  logic              Tx_Busy;
  logic              Tx_Overrun;
  logic              Tx_Valid;
  logic              Tx_Ready;
  logic [DW-1:0]     Tx_OutBUS;
  logic [IW-1:0]     Tx_Index;
  logic              Tx_Last;
  logic              Tx_Done;

  score_stream_tx #(.NUM_CLASSES(N), .DATA_W(DW), .IDX_W(IW)) dut (
    .Tx_Clock   (Tx_Clock),
    .Tx_Reset_n (Tx_Reset_n),
    .Tx_Load    (Tx_Load),
    .Tx_LoadBUS (Tx_LoadBUS),
    .Tx_Busy    (Tx_Busy),
    .Tx_Overrun (Tx_Overrun),
    .Tx_Valid   (Tx_Valid),
    .Tx_Ready   (Tx_Ready),
    .Tx_OutBUS  (Tx_OutBUS),
    .Tx_Index   (Tx_Index),
    .Tx_Last    (Tx_Last),
    .Tx_Done    (Tx_Done)
  );

  initial Tx_Clock = 1'b0;
  always #5 Tx_Clock = ~Tx_Clock;

  int          n_cmp = 0;
  int          n_err = 0;
  word_t       sb[$];
  word_t       mon_word;
  logic        exp_done = 1'b0;
  logic        hold_pending = 1'b0;
  logic [31:0] held_word;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected words for one accepted frame.
  task automatic push_frame(input logic [N*DW-1:0] bus);
    word_t w;
    logic [DW-1:0] sum;
    sum = '0;
    for (int k = 0; k < N; k++) begin
      w.data = bus[k*DW +: DW];
      w.idx  = IW'(k);
`ifdef SCORE_TX_CHECKSUM_EN
      w.last = 1'b0;
`else
      w.last = (k == N - 1);
`endif
      sum = sum + w.data;
      sb.push_back(w);
    end
`ifdef SCORE_TX_CHECKSUM_EN
    w.data = sum;
    w.idx  = '1;
    w.last = 1'b1;
    sb.push_back(w);
`endif
  endtask

  // Monitor: handshake scoreboard, hold stability, Done pulse.
  always @(negedge Tx_Clock) begin
    if (Tx_Reset_n) begin
      check("done", 32'(Tx_Done), 32'(exp_done));
      if (exp_done) begin
        check("valid_after_last", 32'(Tx_Valid), 32'd0);
        check("busy_after_last", 32'(Tx_Busy), 32'd0);
        check("last_after_last", 32'(Tx_Last), 32'd0);
      end
      exp_done = 1'b0;
      if (hold_pending && Tx_Valid)
        check("hold", 32'({Tx_OutBUS, Tx_Index, Tx_Last}), held_word);
      hold_pending = 1'b0;
      if (Tx_Valid && !Tx_Ready) begin
        held_word    = 32'({Tx_OutBUS, Tx_Index, Tx_Last});
        hold_pending = 1'b1;
      end
      if (Tx_Valid && Tx_Ready) begin
        if (sb.size() == 0) begin
          check("unexpected_word", 32'(Tx_Index), 32'hFFFF_FFFF);
        end else begin
          mon_word = sb.pop_front();
          check("data", 32'(Tx_OutBUS), 32'(mon_word.data));
          check("index", 32'(Tx_Index), 32'(mon_word.idx));
          check("last", 32'(Tx_Last), 32'(mon_word.last));
          if (mon_word.last) exp_done = 1'b1;
        end
      end
    end
  end

  // Drive one load pulse of a frame that the DUT must accept.
  task automatic load_frame(input logic [N*DW-1:0] bus);
    Tx_LoadBUS = bus;
    Tx_Load    = 1'b1;
    push_frame(bus);
    @(posedge Tx_Clock); #1;
    Tx_Load = 1'b0;
    check("busy_on_load", 32'(Tx_Busy), 32'd1);
    check("valid_on_load", 32'(Tx_Valid), 32'd1);
    check("index_on_load", 32'(Tx_Index), 32'd0);
  endtask

  // Run until Tx_Done; mode 0 = Ready held high, mode 1 = Ready 1,0,0,1.
  // Returns at posedge+1 of the Done cycle.
  task automatic run_until_done(input int mode, output int cycles);
    logic seen;
    seen   = 1'b0;
    cycles = 0;
    for (int i = 0; i < 200; i++) begin
      Tx_Ready = (mode == 0) ? 1'b1 : ((i % 4 == 0) || (i % 4 == 3));
      @(posedge Tx_Clock); #1;
      cycles++;
      if (Tx_Done) begin
        seen = 1'b1;
        break;
      end
    end
    check("frame_done_timeout", 32'(seen), 32'd1);
    check("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  logic [N*DW-1:0] bus;
  int              cyc;
  logic            found;

  initial begin
    Tx_Reset_n = 1'b0;
    Tx_Load    = 1'b0;
    Tx_LoadBUS = '0;
    Tx_Ready   = 1'b0;
    #23;

    // Reset state
    check("rst_valid", 32'(Tx_Valid), 32'd0);
    check("rst_busy", 32'(Tx_Busy), 32'd0);
    check("rst_last", 32'(Tx_Last), 32'd0);
    check("rst_done", 32'(Tx_Done), 32'd0);
    check("rst_overrun", 32'(Tx_Overrun), 32'd0);
    check("rst_outbus", 32'(Tx_OutBUS), 32'd0);
    check("rst_index", 32'(Tx_Index), 32'd0);
    @(posedge Tx_Clock); #1;
    Tx_Reset_n = 1'b1;
    @(posedge Tx_Clock); #1;

    // 1: scores k*100, Ready high
    for (int k = 0; k < N; k++) bus[k*DW +: DW] = DW'(k * 100);
    Tx_Ready = 1'b1;
    load_frame(bus);
    run_until_done(0, cyc);
`ifdef SCORE_TX_CHECKSUM_EN
    check("frame_cycles", 32'(cyc), 32'(N + 1));
`else
    check("frame_cycles", 32'(cyc), 32'(N));
`endif

    // 2: Ready 1-0-0-1; load lands in the Done cycle of frame 1
    for (int k = 0; k < N; k++) bus[k*DW +: DW] = DW'(16'h1000 + k * 3);
    load_frame(bus);
    run_until_done(1, cyc);

    // 5: signed extremes, again loaded in the Done cycle
    bus = '0;
    bus[0*DW +: DW] = 16'h8000;
    bus[1*DW +: DW] = 16'h7FFF;
    bus[2*DW +: DW] = 16'hFFFF;
    Tx_Ready = 1'b1;
    load_frame(bus);
    run_until_done(0, cyc);

    // 3: second load during the 3rd word -> Overrun, first frame continues
    @(posedge Tx_Clock); #1;
    for (int k = 0; k < N; k++) bus[k*DW +: DW] = DW'(k * 7 + 3);
    Tx_Ready = 1'b1;
    load_frame(bus);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (Tx_Index == 4'd2) begin
        found = 1'b1;
        break;
      end
      @(posedge Tx_Clock); #1;
    end
    check("reach_word3", 32'(found), 32'd1);
    Tx_LoadBUS = {N{16'hDEAD}};
    Tx_Load    = 1'b1;
    @(posedge Tx_Clock); #1;
    Tx_Load = 1'b0;
    check("overrun_pulse", 32'(Tx_Overrun), 32'd1);
    check("busy_during_overrun", 32'(Tx_Busy), 32'd1);
    @(posedge Tx_Clock); #1;
    check("overrun_clear", 32'(Tx_Overrun), 32'd0);
    run_until_done(0, cyc);

    // 4: reset at index 5 with Ready low
    @(posedge Tx_Clock); #1;
    for (int k = 0; k < N; k++) bus[k*DW +: DW] = DW'(16'h0500 + k);
    Tx_Ready = 1'b1;
    load_frame(bus);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge Tx_Clock); #1;
      if (Tx_Index == 4'd5) begin
        found = 1'b1;
        break;
      end
    end
    check("reach_index5", 32'(found), 32'd1);
    Tx_Ready = 1'b0;
    @(posedge Tx_Clock); #2;
    Tx_Reset_n = 1'b0;
    sb.delete();
    #1;
    check("midrst_valid", 32'(Tx_Valid), 32'd0);
    check("midrst_busy", 32'(Tx_Busy), 32'd0);
    check("midrst_index", 32'(Tx_Index), 32'd0);
    check("midrst_outbus", 32'(Tx_OutBUS), 32'd0);
    check("midrst_last", 32'(Tx_Last), 32'd0);
    #20;
    @(posedge Tx_Clock); #1;
    Tx_Reset_n = 1'b1;
    @(posedge Tx_Clock); #1;
    check("postrst_done", 32'(Tx_Done), 32'd0);
    for (int k = 0; k < N; k++) bus[k*DW +: DW] = DW'(16'hA000 + k * 11);
    Tx_Ready = 1'b1;
    load_frame(bus);
    run_until_done(0, cyc);

`ifdef SCORE_TX_CHECKSUM_EN
    // 6: all 16'h2000 -> checksum word 16'h4000
    bus = {N{16'h2000}};
    load_frame(bus);
    check("chk_model_sum", 32'(sb[N].data), 32'h4000);
    run_until_done(0, cyc);
`endif

    @(posedge Tx_Clock); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
